// File: rtl/compare_sorter_pkg.sv
// compare_sorter_pkg
//   Shared definitions for the compare_sorter block: FSM state encoding
//   and the width of the saturating swap counter.
package compare_sorter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SWAP_W = 8;

endpackage

// File: rtl/compare_sorter_cmp_swap.sv
// cmp_swap
//   Compare-and-order element for one adjacent pair of the sorter.
//   Ports:
//     a, b    : element at the lower / higher index of the pair
//     desc    : 0 = ascending, 1 = descending
//     lo_pos  : value to place at the lower index
//     hi_pos  : value to place at the higher index
//     swap    : 1 when the pair is out of order (equal values never swap)
module cmp_swap #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             desc,
  output logic [WIDTH-1:0] lo_pos,
  output logic [WIDTH-1:0] hi_pos,
  output logic             swap
);

  // Strict comparisons keep equal elements in place, which makes the sort stable.
  assign swap   = desc ? (a < b) : (a > b);
  assign lo_pos = swap ? b : a;
  assign hi_pos = swap ? a : b;

endmodule

// File: rtl/compare_sorter.sv
// compare_sorter
//   In-place bubble sorter over a small register array. Elements are loaded
//   through a write port while idle, sorted on request one adjacent pair per
//   cycle, and read back through a combinational read port.
//   Ports:
//     clk, rst          : clock, asynchronous active-high reset
//     wr_en/addr/data   : element write (idle only; out-of-range addresses ignored)
//     start, desc       : one-cycle sort request and its order (0 = ascending)
//     rd_addr, rd_data  : combinational element read (0 when out of range)
//     busy              : high while scanning
//     done              : one-cycle completion pulse
//     swaps             : swaps performed by the current/last sort, saturating
module compare_sorter
  import compare_sorter_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              start,
  input  logic              desc,
  input  logic [AW-1:0]     rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic              busy,
  output logic              done,
  output logic [SWAP_W-1:0] swaps
);

  localparam logic [AW:0]   DEPTH_W    = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LIMIT_INIT = AW'(DEPTH - 2);

  state_t             r_state;
  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [AW-1:0]      r_idx;
  logic [AW-1:0]      r_limit;
  logic               r_desc;
  logic               r_pass_swapped;
  logic               r_busy;
  logic               r_done;
  logic [SWAP_W-1:0]  r_swaps;

  logic [AW-1:0]      w_idx_nxt;
  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;
  logic [WIDTH-1:0]   w_lo;
  logic [WIDTH-1:0]   w_hi;
  logic               w_swap;
  logic               w_pass_any;
  logic               w_wr_ok;

  // idx never exceeds DEPTH-2, so idx+1 always addresses a real element.
  assign w_idx_nxt  = r_idx + AW'(1);
  assign w_a        = r_mem[r_idx];
  assign w_b        = r_mem[w_idx_nxt];
  // The pass-end decision must see a swap made in the same cycle.
  assign w_pass_any = r_pass_swapped | w_swap;
  assign w_wr_ok    = wr_en && ({1'b0, wr_addr} < DEPTH_W);

  cmp_swap #(
    .WIDTH (WIDTH)
  ) u_cmp_swap (
    .a      (w_a),
    .b      (w_b),
    .desc   (r_desc),
    .lo_pos (w_lo),
    .hi_pos (w_hi),
    .swap   (w_swap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_idx          <= '0;
      r_limit        <= '0;
      r_desc         <= 1'b0;
      r_pass_swapped <= 1'b0;
      r_swaps        <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          // A write coincident with start lands before the first compare.
          if (w_wr_ok) r_mem[wr_addr] <= wr_data;
          if (start) begin
            r_desc         <= desc;
            r_swaps        <= '0;
            r_idx          <= '0;
            r_limit        <= LIMIT_INIT;
            r_pass_swapped <= 1'b0;
            r_busy         <= 1'b1;
            r_state        <= SCAN;
          end
        end

        SCAN: begin
          r_mem[r_idx]     <= w_lo;
          r_mem[w_idx_nxt] <= w_hi;
          if (w_swap && (r_swaps != '1)) r_swaps <= r_swaps + 1'b1;
          if (r_idx != r_limit) begin
            r_idx          <= w_idx_nxt;
            r_pass_swapped <= w_pass_any;
          end else if (!w_pass_any || (r_limit == '0)) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            // Last element of this pass is now in its final place.
            r_limit        <= r_limit - AW'(1);
            r_idx          <= '0;
            r_pass_swapped <= 1'b0;
          end
        end

        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    if ({1'b0, rd_addr} < DEPTH_W) rd_data = r_mem[rd_addr];
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign swaps = r_swaps;

endmodule

// File: tb/tb_compare_sorter.sv
// tb_compare_sorter
//   Randomized and directed stimulus for compare_sorter (WIDTH=8, DEPTH=4).
//   Expected results come from an order-statistics reference model: final
//   contents by library sort, swap count by inversion count, scan length by
//   the largest per-element count of out-of-order predecessors.
module tb_compare_sorter;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  typedef struct {
    logic [DEPTH-1:0][WIDTH-1:0] arr;
    int swaps;
    int scan;
    int start_cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wr_en = 1'b0;
  logic [AW-1:0]    wr_addr = '0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             start = 1'b0;
  logic             desc = 1'b0;
  logic [AW-1:0]    rd_addr = '0;
  logic [WIDTH-1:0] rd_data;
  logic             busy;
  logic             done;
  logic [7:0]       swaps;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   zero_req = 0;
  exp_t sb[$];

  compare_sorter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .start   (start),
    .desc    (desc),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .busy    (busy),
    .done    (done),
    .swaps   (swaps)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DEPTH-1:0][WIDTH-1:0] mk(input int e0, input int e1,
                                                      input int e2, input int e3);
    logic [DEPTH-1:0][WIDTH-1:0] a;
    a[0] = e0[7:0]; a[1] = e1[7:0]; a[2] = e2[7:0]; a[3] = e3[7:0];
    return a;
  endfunction

  function automatic exp_t model(input logic [DEPTH-1:0][WIDTH-1:0] a, input bit d);
    exp_t e;
    int   q[$];
    int   inv = 0;
    int   k = 0;
    int   passes;
    for (int j = 0; j < DEPTH; j++) begin
      int cnt = 0;
      for (int i = 0; i < j; i++)
        if (d ? (a[i] < a[j]) : (a[i] > a[j])) cnt++;
      inv += cnt;
      if (cnt > k) k = cnt;
    end
    for (int i = 0; i < DEPTH; i++) q.push_back(int'(a[i]));
    if (d) q.rsort(); else q.sort();
    for (int i = 0; i < DEPTH; i++) e.arr[i] = q[i][7:0];
    // k passes move every element home; one more pass confirms, unless passes run out.
    passes = (k + 1 < DEPTH - 1) ? k + 1 : DEPTH - 1;
    e.scan = 0;
    for (int p = 1; p <= passes; p++) e.scan += DEPTH - p;
    e.swaps = (inv > 255) ? 255 : inv;
    e.start_cyc = 0;
    return e;
  endfunction

  // Monitor: pops the scoreboard on each done pulse.
  initial begin : monitor
    int   busy_cnt = 0;
    int   zero_ack = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_cnt = 0;
      end else begin
        if (busy) busy_cnt++;
        if (done) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("swaps", int'(swaps), e.swaps);
            chk("busy_cycles", busy_cnt, e.scan);
            chk("done_latency", cyc - e.start_cyc, e.scan);
            for (int i = 0; i < DEPTH; i++) begin
              rd_addr = AW'(i);
              #1;
              chk($sformatf("elem%0d", i), int'(rd_data), int'(e.arr[i]));
            end
          end
        end
        if (!busy && !done) busy_cnt = 0;
        if (zero_req != zero_ack) begin
          zero_ack = zero_req;
          for (int i = 0; i < DEPTH; i++) begin
            rd_addr = AW'(i);
            #1;
            chk($sformatf("reset_elem%0d", i), int'(rd_data), 0);
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load(input logic [DEPTH-1:0][WIDTH-1:0] a);
    for (int i = 0; i < DEPTH; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = a[i];
      @(negedge clk);
    end
    wr_en = 1'b0;
  endtask

  task automatic wait_empty();
    int t = 0;
    while (sb.size() != 0 && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", 0, 1);
      sb.delete();
      do_reset();
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic run_sort(input logic [DEPTH-1:0][WIDTH-1:0] a, input bit d,
                          input bit co_wr, input int co_addr, input int co_data,
                          input bit disturb, output int exp_swaps);
    logic [DEPTH-1:0][WIDTH-1:0] m;
    exp_t e;
    load(a);
    m = a;
    if (co_wr) begin
      m[co_addr] = co_data[7:0];
      wr_en = 1'b1; wr_addr = AW'(co_addr); wr_data = co_data[7:0];
    end
    e = model(m, d);
    e.start_cyc = cyc + 1;
    exp_swaps = e.swaps;
    sb.push_back(e);
    start = 1'b1; desc = d;
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    if (disturb) begin
      wr_en = 1'b1; wr_addr = '0; wr_data = 8'd9; start = 1'b1; desc = ~d;
      @(negedge clk);
      wr_en = 1'b0; start = 1'b0;
    end
    wait_empty();
  endtask

  initial begin : stimulus
    int es;
    logic [DEPTH-1:0][WIDTH-1:0] ra;
    @(negedge clk);
    do_reset();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_swaps", int'(swaps), 0);
    zero_req++;
    @(negedge clk);
    @(negedge clk);

    run_sort(mk(3, 1, 2, 0), 1'b0, 1'b0, 0, 0, 1'b0, es);
    repeat (3) @(negedge clk);
    chk("swaps_hold_idle", int'(swaps), es);
    run_sort(mk(0, 1, 2, 3), 1'b0, 1'b0, 0, 0, 1'b0, es);
    run_sort(mk(0, 1, 2, 3), 1'b1, 1'b0, 0, 0, 1'b0, es);
    run_sort(mk(5, 5, 5, 5), 1'b0, 1'b0, 0, 0, 1'b0, es);
    run_sort(mk(255, 0, 255, 0), 1'b0, 1'b0, 0, 0, 1'b0, es);
    run_sort(mk(4, 7, 1, 6), 1'b0, 1'b0, 0, 0, 1'b1, es);
    run_sort(mk(4, 7, 1, 6), 1'b1, 1'b1, 2, 200, 1'b0, es);

    // Abort mid-scan: no done, everything back to zero.
    load(mk(3, 1, 2, 0));
    start = 1'b1; desc = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    sb.delete();
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_swaps", int'(swaps), 0);
    @(negedge clk);
    rst = 1'b0;
    zero_req++;
    repeat (12) @(negedge clk);

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < DEPTH; i++)
        ra[i] = (n % 2 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      run_sort(ra, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 255)),
               1'($urandom_range(0, 1)), es);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
